mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port RAM with lock support and 1-cycle read return.
// Define ARB_FIXED_PRIO_EN to make IDLE ties always go to m0 instead of round-robin.
module mem_arbiter #(
   parameter int MAX_LOCK = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_lock,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_lock,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        ram_en,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic [3:0]  ram_wstrb,
   input  logic [31:0] ram_rdata
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOCK0 = 2'd1;
   localparam logic [1:0] LOCK1 = 2'd2;
   localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

   logic [1:0] state;
   logic [7:0] lock_cnt;
   logic       pend0;
   logic       pend1;
   logic       tie_to_m0;
   logic       exit0;
   logic       exit1;

`ifdef ARB_FIXED_PRIO_EN
   assign tie_to_m0 = 1'b1;
`else
   logic last_winner;
   // last_winner == 1 means m1 won most recently, so m0 takes the next tie.
   assign tie_to_m0 = last_winner;
`endif

   assign exit0 = (state == LOCK0) && (!m0_lock || lock_cnt == LOCK_LAST);
   assign exit1 = (state == LOCK1) && (!m1_lock || lock_cnt == LOCK_LAST);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
      case (state)
         LOCK0:   m0_gnt = m0_req;
         LOCK1:   m1_gnt = m1_req;
         default: begin
            if (m0_req && m1_req) begin
               m0_gnt = tie_to_m0;
               m1_gnt = !tie_to_m0;
            end else begin
               m0_gnt = m0_req;
               m1_gnt = m1_req;
            end
         end
      endcase
   end

   assign ram_en    = m0_gnt | m1_gnt;
   assign ram_addr  = m1_gnt ? m1_addr  : m0_addr;
   assign ram_wdata = m1_gnt ? m1_wdata : m0_wdata;
   assign ram_wstrb = m0_gnt ? m0_wstrb : (m1_gnt ? m1_wstrb : 4'b0000);

   assign m0_rvalid = pend0;
   assign m1_rvalid = pend1;
   assign m0_rdata  = pend0 ? ram_rdata : 32'h0;
   assign m1_rdata  = pend1 ? ram_rdata : 32'h0;

   // Grants stay combinational during reset; only the registered state is held.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      if (reset) begin
         state    <= IDLE;
         lock_cnt <= 8'd0;
         pend0    <= 1'b0;
         pend1    <= 1'b0;
      end else begin
         pend0 <= m0_gnt && (m0_wstrb == 4'b0000);
         pend1 <= m1_gnt && (m1_wstrb == 4'b0000);
         case (state)
            LOCK0: begin
               if (exit0) begin
                  state    <= IDLE;
                  lock_cnt <= 8'd0;
               end else begin
                  lock_cnt <= lock_cnt + 8'd1;
               end
            end
            LOCK1: begin
               if (exit1) begin
                  state    <= IDLE;
                  lock_cnt <= 8'd0;
               end else begin
                  lock_cnt <= lock_cnt + 8'd1;
               end
            end
            default: begin
               lock_cnt <= 8'd0;
               if (m0_gnt && m0_lock)
                  state <= LOCK0;
               else if (m1_gnt && m1_lock)
                  state <= LOCK1;
               else
                  state <= IDLE;
            end
         endcase
      end
   end

`ifndef ARB_FIXED_PRIO_EN
   always_ff @(posedge clk) begin
      if (reset)
         last_winner <= 1'b1;
      else if (state != LOCK0 && state != LOCK1 && ram_en)
         last_winner <= m1_gnt;
      else if (exit0)
         last_winner <= 1'b0;
      else if (exit1)
         last_winner <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MAX_LOCK=4): round-robin, writes, lock timeout, lock with idle req, reset.
module tb_mem_arbiter;

   localparam logic [31:0] MAGIC = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_lock, m1_req, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_en;
   logic [31:0] ram_addr, ram_wdata;
   logic [3:0]  ram_wstrb;
   logic [31:0] ram_rdata = 32'h0;

   int n_cmp = 0;
   int n_bad = 0;

   logic        exp_rv0 = 1'b0, exp_rv1 = 1'b0;
   logic [31:0] exp_rd0 = 32'h0, exp_rd1 = 32'h0;

   always #5 clk = ~clk;

   // RAM model: returns address ^ MAGIC one cycle after the command.
   always @(posedge clk) ram_rdata <= ram_addr ^ MAGIC;

   mem_arbiter #(.MAX_LOCK(4)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
      .ram_rdata(ram_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks one cycle's combinational outputs and the read return owed from the previous cycle,
   // then records the read return owed by this cycle and advances to 1 time unit past the edge.
   task automatic run_cycle(input logic e_g0, input logic e_g1, input string tag);
      logic [3:0] e_strb;
      #1;
      e_strb = e_g0 ? m0_wstrb : (e_g1 ? m1_wstrb : 4'b0000);
      chk({tag, ".m0_gnt"}, {31'h0, m0_gnt}, {31'h0, e_g0});
      chk({tag, ".m1_gnt"}, {31'h0, m1_gnt}, {31'h0, e_g1});
      chk({tag, ".ram_en"}, {31'h0, ram_en}, {31'h0, e_g0 | e_g1});
      chk({tag, ".ram_wstrb"}, {28'h0, ram_wstrb}, {28'h0, e_strb});
      if (e_g0 | e_g1) begin
         chk({tag, ".ram_addr"}, ram_addr, e_g0 ? m0_addr : m1_addr);
         chk({tag, ".ram_wdata"}, ram_wdata, e_g0 ? m0_wdata : m1_wdata);
      end
      chk({tag, ".m0_rvalid"}, {31'h0, m0_rvalid}, {31'h0, exp_rv0});
      chk({tag, ".m1_rvalid"}, {31'h0, m1_rvalid}, {31'h0, exp_rv1});
      chk({tag, ".m0_rdata"}, m0_rdata, exp_rv0 ? exp_rd0 : 32'h0);
      chk({tag, ".m1_rdata"}, m1_rdata, exp_rv1 ? exp_rd1 : 32'h0);
      exp_rv0 = e_g0 && (m0_wstrb == 4'b0000) && !reset;
      exp_rv1 = e_g1 && (m1_wstrb == 4'b0000) && !reset;
      exp_rd0 = m0_addr ^ MAGIC;
      exp_rd1 = m1_addr ^ MAGIC;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic fixed;
`ifdef ARB_FIXED_PRIO_EN
      fixed = 1'b1;
`else
      fixed = 1'b0;
`endif
      reset = 1'b1;
      m0_req = 0; m0_lock = 0; m0_addr = 32'h10; m0_wdata = 32'h0; m0_wstrb = 4'h0;
      m1_req = 0; m1_lock = 0; m1_addr = 32'h20; m1_wdata = 32'h0; m1_wstrb = 4'h0;
      @(posedge clk);
      #1;

      // Read granted while reset is high: grant visible, no response afterwards.
      m0_req = 1;
      run_cycle(1'b1, 1'b0, "rst_gnt");
      reset = 0;
      m0_req = 0;
      run_cycle(1'b0, 1'b0, "post_rst");

      // Both read for 4 cycles: alternate starting with m0 (fixed build: m0 every time).
      m0_req = 1; m1_req = 1;
      for (int i = 0; i < 4; i++) begin
         logic g0;
         g0 = fixed || (i % 2 == 0);
         run_cycle(g0, !g0, "rr");
      end
      m0_req = 0; m1_req = 0;
      run_cycle(1'b0, 1'b0, "rr_tail");

      // m1 partial write: no read response.
      m1_req = 1; m1_addr = 32'h40; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
      run_cycle(1'b0, 1'b1, "wr");
      m1_req = 0; m1_addr = 32'h20; m1_wdata = 32'h0; m1_wstrb = 4'h0;
      run_cycle(1'b0, 1'b0, "wr_tail");

      // m0 locks with m1 requesting: 5 m0 grants, then m1 wins the tie.
      m0_req = 1; m0_lock = 1; m1_req = 1;
      for (int i = 0; i < 6; i++) begin
         logic g0;
         g0 = (i < 5) || fixed;
         run_cycle(g0, !g0, "lock_max");
      end

      // m0 holds the lock but pauses its requests: nobody is granted.
      m1_req = 0;
      run_cycle(1'b1, 1'b0, "lock_enter");
      m0_req = 0; m1_req = 1;
      run_cycle(1'b0, 1'b0, "lock_gap0");
      run_cycle(1'b0, 1'b0, "lock_gap1");
      m0_lock = 0;
      run_cycle(1'b0, 1'b0, "lock_rel");
      run_cycle(1'b0, 1'b1, "after_rel");
      m1_req = 0;
      run_cycle(1'b0, 1'b0, "final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
